video_sprite_motion_ctrl: RTL

// - Avalon-MM write initiator driving the register port of the sprite animation core.
// - After reset it programs ctrl, sprite_rate and the initial x/y origin.
// - Once per frame_tick it moves the sprite by a signed velocity and writes the new x_origin/y_origin.
// - Sits between the frame-timing logic and the sprite core's avs_* slave port.

---
 rtl/video_sprite_motion_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/video_sprite_motion_ctrl.sv
// Sprite motion controller: Avalon-MM write initiator that initialises the
// sprite core and moves the sprite once per frame_tick by a signed velocity.
// Build option: define SPRITE_BOUNCE_EN for edge bounce instead of wrap-around.
module video_sprite_motion_ctrl #(
    parameter int AW           = 13,
    parameter int H_DISPLAY    = 640,
    parameter int V_DISPLAY    = 480,
    parameter int SPRITE_HSIZE = 32,
    parameter int SPRITE_VSIZE = 32,
    parameter int X_INIT       = 0,
    parameter int Y_INIT       = 0,
    parameter int VX_INIT      = 1,
    parameter int VY_INIT      = 1,
    parameter int VEL_W        = 8,
    parameter int SPRITE_RATE  = 25000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             vel_wr,
    input  logic [VEL_W-1:0] vel_vx,
    input  logic [VEL_W-1:0] vel_vy,
    output logic             avm_write,
    output logic [AW-1:0]    avm_address,
    output logic [31:0]      avm_writedata,
    input  logic             avm_waitrequest,
    output logic             busy,
    output logic [7:0]       missed_frames
);

    localparam logic signed [16:0] XMAX = 17'(H_DISPLAY - SPRITE_HSIZE);
    localparam logic signed [16:0] YMAX = 17'(V_DISPLAY - SPRITE_VSIZE);

    localparam logic [AW-1:0] ADDR_CTRL = AW'(0);
    localparam logic [AW-1:0] ADDR_X    = AW'(4);
    localparam logic [AW-1:0] ADDR_Y    = AW'(8);
    localparam logic [AW-1:0] ADDR_RATE = AW'(12);

    typedef enum logic [2:0] {
        INIT_CTRL,
        INIT_RATE,
        INIT_X,
        INIT_Y,
        IDLE,
        CALC,
        WR_X,
        WR_Y
    } state_t;

    state_t state;
    state_t state_next;

    logic [15:0]       x;
    logic [15:0]       y;
    logic [VEL_W-1:0]  vx;
    logic [VEL_W-1:0]  vy;

    logic [16+VEL_W-1:0] sx;
    logic [16+VEL_W-1:0] sy;
    logic [15:0]         nx;
    logic [15:0]         ny;
    logic [VEL_W-1:0]    nvx;
    logic [VEL_W-1:0]    nvy;

    logic              done;
    logic              write_d;
    logic [AW-1:0]     addr_d;
    logic [31:0]       data_d;

    // One axis step: returns {new position, new velocity}.
    function automatic logic [16+VEL_W-1:0] step_axis(
        input logic [15:0]        p,
        input logic [VEL_W-1:0]   v,
        input logic signed [16:0] lim
    );
        logic signed [16:0] n;
        logic [15:0]        np;
        logic [VEL_W-1:0]   nv;
        n = $signed({1'b0, p}) + $signed({{(17-VEL_W){v[VEL_W-1]}}, v});
`ifdef SPRITE_BOUNCE_EN
        np = n[15:0];
        nv = v;
        if (n > lim) begin
            np = lim[15:0];
            nv = -v;
        end else if (n < 17'sd0) begin
            np = '0;
            nv = -v;
        end
`else
        if (n > lim) begin
            n = n - lim - 17'sd1;
        end else if (n < 17'sd0) begin
            n = n + lim + 17'sd1;
        end
        np = n[15:0];
        nv = v;
`endif
        return {np, nv};
    endfunction

    assign sx  = step_axis(x, vx, XMAX);
    assign sy  = step_axis(y, vy, YMAX);
    assign nx  = sx[16+VEL_W-1:VEL_W];
    assign nvx = sx[VEL_W-1:0];
    assign ny  = sy[16+VEL_W-1:VEL_W];
    assign nvy = sy[VEL_W-1:0];

    assign done = avm_write & ~avm_waitrequest;
    assign busy = (state != IDLE);

    // State register plus registered Avalon request for the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= INIT_CTRL;
            avm_write     <= 1'b0;
            avm_address   <= '0;
            avm_writedata <= '0;
        end else begin
            state         <= state_next;
            avm_write     <= write_d;
            avm_address   <= addr_d;
            avm_writedata <= data_d;
        end
    end

    // Next state, and the write the next state will present.
    always_comb begin
        state_next = state;
        write_d    = 1'b0;
        addr_d     = '0;
        data_d     = '0;
        unique case (state)
            INIT_CTRL: if (done) state_next = INIT_RATE;
            INIT_RATE: if (done) state_next = INIT_X;
            INIT_X:    if (done) state_next = INIT_Y;
            INIT_Y:    if (done) state_next = IDLE;
            IDLE:      if (frame_tick && enable) state_next = CALC;
            CALC:      state_next = WR_X;
            WR_X:      if (done) state_next = WR_Y;
            WR_Y:      if (done) state_next = IDLE;
        endcase
        unique case (state_next)
            INIT_CTRL: begin
                write_d = 1'b1;
                addr_d  = ADDR_CTRL;
            end
            INIT_RATE: begin
                write_d = 1'b1;
                addr_d  = ADDR_RATE;
                data_d  = 32'(SPRITE_RATE);
            end
            INIT_X: begin
                write_d = 1'b1;
                addr_d  = ADDR_X;
                data_d  = {16'b0, x};
            end
            INIT_Y: begin
                write_d = 1'b1;
                addr_d  = ADDR_Y;
                data_d  = {16'b0, y};
            end
            IDLE, CALC: begin
                write_d = 1'b0;
            end
            // Entering from CALC the position register is updated on the
            // same edge, so take the freshly computed value.
            WR_X: begin
                write_d = 1'b1;
                addr_d  = ADDR_X;
                data_d  = {16'b0, (state == CALC) ? nx : x};
            end
            WR_Y: begin
                write_d = 1'b1;
                addr_d  = ADDR_Y;
                data_d  = {16'b0, (state == CALC) ? ny : y};
            end
        endcase
    end

    // Position/velocity update and dropped-tick counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            x             <= 16'(X_INIT);
            y             <= 16'(Y_INIT);
            vx            <= VEL_W'(VX_INIT);
            vy            <= VEL_W'(VY_INIT);
            missed_frames <= '0;
        end else begin
            if (state == CALC) begin
                x  <= nx;
                y  <= ny;
                vx <= nvx;
                vy <= nvy;
            end
            // A host velocity write overrides the CALC result.
            if (vel_wr) begin
                vx <= vel_vx;
                vy <= vel_vy;
            end
            if (frame_tick && state != IDLE && missed_frames != 8'hFF) begin
                missed_frames <= missed_frames + 8'd1;
            end
        end
    end

endmodule
